// File: rtl/core_fpu_issue_if.sv
// Decode-to-FP-issue handshake plus the dispatch and writeback signals leaving the scheduler.
// issue_valid/issue_ready: the op transfers on a clock edge where both are high; issue_ready may depend on issue_op.
interface core_fpu_issue_if;
    logic       issue_valid;
    logic [3:0] issue_op;
    logic [4:0] issue_rd;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_ready;
    logic       fpu_start;
    logic [3:0] fpu_op;
    logic       fpu_divbusy;
    logic       wb_valid;
    logic [4:0] wb_num;
    logic       wb_is_f;
    logic       illegal;

    modport master (
        output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
        input  issue_ready, fpu_start, fpu_op, fpu_divbusy, wb_valid, wb_num, wb_is_f, illegal
    );

    modport slave (
        input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
        output issue_ready, fpu_start, fpu_op, fpu_divbusy, wb_valid, wb_num, wb_is_f, illegal
    );
endinterface

// File: rtl/core_fpu_issue.sv
// FP issue scheduler: hazard scoreboards, writeback slot ring and iterative-unit tracking.
// Optional feature macro FPU_SQRT_EN: when undefined, FSQRT (op 4) is handled as an illegal op.
module core_fpu_issue #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 2,
    parameter int LAT_CVT  = 2,
    parameter int LAT_MISC = 1,
    parameter int LAT_DIV  = 10,
    parameter int LAT_SQRT = 10
) (
    input logic             clk,
    input logic             rst,
    core_fpu_issue_if.slave bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LAT_MAX = max2(max2(max2(LAT_ADD, LAT_MUL), max2(LAT_CVT, LAT_MISC)),
                                  max2(LAT_DIV, LAT_SQRT));
    localparam int DEPTH   = LAT_MAX + 1;
    localparam int CW      = $clog2(max2(LAT_DIV, LAT_SQRT) + 1);

    // Ring entry i retires i cycles from now; entry 0 drives the writeback port.
    logic [DEPTH-1:0] ring_v, ring_v_n;
    logic [DEPTH-1:0] ring_f, ring_f_n;
    logic [4:0]       ring_num   [DEPTH];
    logic [4:0]       ring_num_n [DEPTH];
    logic [31:0]      sb_f, sb_f_n, sb_i, sb_i_n;
    logic [CW-1:0]    div_cnt;
    logic             fpu_start_q, illegal_q;
    logic [3:0]       fpu_op_q;

    logic       is_illegal, is_iter, rs1_int, use_rs2, rd_int;
    logic       rs1_pend, rs2_pend, rd_pend, slot_busy, div_block;
    logic       ready, fire, dispatch;
    int         lat;
    logic [3:0] op;

    always_comb begin
        op         = bus.issue_op;
        is_illegal = (op >= 4'd12);
`ifndef FPU_SQRT_EN
        if (op == 4'd4) is_illegal = 1'b1;
`endif
        is_iter = !is_illegal && (op == 4'd3 || op == 4'd4);
        rs1_int = (op == 4'd9) || (op == 4'd10);
        use_rs2 = (op <= 4'd3) || (op >= 4'd5 && op <= 4'd8);
        rd_int  = (op == 4'd6) || (op == 4'd7) || (op == 4'd8) || (op == 4'd11);
        case (op)
            4'd0, 4'd1:   lat = LAT_ADD;
            4'd2:         lat = LAT_MUL;
            4'd3:         lat = LAT_DIV;
            4'd4:         lat = LAT_SQRT;
            4'd10, 4'd11: lat = LAT_CVT;
            default:      lat = LAT_MISC;
        endcase

        rs1_pend = rs1_int ? sb_i[bus.issue_rs1] : sb_f[bus.issue_rs1];
        rs2_pend = use_rs2 && sb_f[bus.issue_rs2];
        rd_pend  = rd_int ? sb_i[bus.issue_rd] : sb_f[bus.issue_rd];
        // The slot this op needs sits one place further up the ring before this edge's shift.
        slot_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == lat + 1) slot_busy = ring_v[i];
        end
        div_block = is_iter && (div_cnt != '0);

        ready    = !rst && (is_illegal || !(rs1_pend || rs2_pend || rd_pend || slot_busy || div_block));
        fire     = bus.issue_valid && ready;
        dispatch = fire && !is_illegal;
    end

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            ring_v_n[i]   = ring_v[i+1];
            ring_f_n[i]   = ring_f[i+1];
            ring_num_n[i] = ring_num[i+1];
        end
        ring_v_n[DEPTH-1]   = 1'b0;
        ring_f_n[DEPTH-1]   = 1'b0;
        ring_num_n[DEPTH-1] = 5'd0;
        if (dispatch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == lat) begin
                    ring_v_n[i]   = 1'b1;
                    ring_f_n[i]   = !rd_int;
                    ring_num_n[i] = bus.issue_rd;
                end
            end
        end

        sb_f_n = sb_f;
        sb_i_n = sb_i;
        if (ring_v[0]) begin
            if (ring_f[0]) sb_f_n[ring_num[0]] = 1'b0;
            else           sb_i_n[ring_num[0]] = 1'b0;
        end
        if (dispatch) begin
            if (rd_int) sb_i_n[bus.issue_rd] = 1'b1;
            else        sb_f_n[bus.issue_rd] = 1'b1;
        end
        sb_i_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_v      <= '0;
            ring_f      <= '0;
            sb_f        <= '0;
            sb_i        <= '0;
            div_cnt     <= '0;
            fpu_start_q <= 1'b0;
            fpu_op_q    <= 4'd0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ring_num[i] <= 5'd0;
        end else begin
            ring_v      <= ring_v_n;
            ring_f      <= ring_f_n;
            sb_f        <= sb_f_n;
            sb_i        <= sb_i_n;
            fpu_start_q <= dispatch;
            illegal_q   <= fire && is_illegal;
            if (dispatch) fpu_op_q <= op;
            for (int i = 0; i < DEPTH; i++) ring_num[i] <= ring_num_n[i];
            if (dispatch && is_iter)
                div_cnt <= (op == 4'd3) ? CW'(LAT_DIV) : CW'(LAT_SQRT);
            else if (div_cnt != '0)
                div_cnt <= div_cnt - 1'b1;
        end
    end

    assign bus.issue_ready = ready;
    assign bus.fpu_start   = fpu_start_q;
    assign bus.fpu_op      = fpu_op_q;
    assign bus.fpu_divbusy = (div_cnt != '0);
    assign bus.wb_valid    = ring_v[0];
    assign bus.wb_num      = ring_num[0];
    assign bus.wb_is_f     = ring_f[0];
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_core_fpu_issue.sv
// Directed bench for core_fpu_issue: issue timing checked inline, writebacks checked by a queue-driven monitor.
module tb_core_fpu_issue;
    localparam int W = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_a, mon_e;

    core_fpu_issue_if bus();

    core_fpu_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Driver: hold one op valid until accepted, check its fire cycle and dispatch pulse, queue its writeback.
    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input int exp_cyc, input bit exp_wb,
                         input bit exp_ill, input int lat, input bit isf);
        int fire_cyc;
        bit fired;
        fired          = 1'b0;
        fire_cyc       = -1;
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_rd    = rd;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        for (int k = 0; k < 40 && !fired; k++) begin
            @(negedge clk);
            if (bus.issue_ready) begin
                fired    = 1'b1;
                fire_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.issue_valid = 1'b0;
        check("fire_cycle", fire_cyc, exp_cyc);
        if (fired) begin
            check("fpu_start", int'(bus.fpu_start), int'(!exp_ill));
            check("illegal", int'(bus.illegal), int'(exp_ill));
            if (!exp_ill) check("fpu_op", int'(bus.fpu_op), int'(op));
            if (exp_wb) exp_q.push_back({16'(fire_cyc + 1 + lat), rd, isf});
        end
    endtask

    // Monitor: every writeback must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (bus.wb_valid) begin
            mon_a = {cyc[15:0], bus.wb_num, bus.wb_is_f};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got cycle %0d num %0d is_f %0d, required no writeback",
                         cyc, bus.wb_num, bus.wb_is_f);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb {cycle,num,is_f}", int'(mon_a), int'(mon_e));
            end
        end
    end

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_op    = 4'd0;
        bus.issue_rd    = 5'd0;
        bus.issue_rs1   = 5'd0;
        bus.issue_rs2   = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_wb_valid", int'(bus.wb_valid), 0);
        check("rst_wb_num", int'(bus.wb_num), 0);
        check("rst_wb_is_f", int'(bus.wb_is_f), 0);
        check("rst_fpu_start", int'(bus.fpu_start), 0);
        check("rst_fpu_op", int'(bus.fpu_op), 0);
        check("rst_divbusy", int'(bus.fpu_divbusy), 0);
        check("rst_illegal", int'(bus.illegal), 0);
        issue(4'd0, 5'd1, 5'd2, 5'd3, cyc, 1'b1, 1'b0, 3, 1'b1);
        idle(10);

        // RAW: FADD f3 then FMUL f4,f3,f3
        t = cyc;
        issue(4'd0, 5'd3, 5'd1, 5'd2, t, 1'b1, 1'b0, 3, 1'b1);
        issue(4'd2, 5'd4, 5'd3, 5'd3, t + 5, 1'b1, 1'b0, 2, 1'b1);
        idle(10);

        // Iterative unit: two FDIVs, busy window between them
        t = cyc;
        issue(4'd3, 5'd5, 5'd1, 5'd2, t, 1'b1, 1'b0, 10, 1'b1);
        fork
            issue(4'd3, 5'd6, 5'd10, 5'd11, t + 11, 1'b1, 1'b0, 10, 1'b1);
            begin
                for (int k = 0; k < 10; k++) begin
                    check("divbusy_high", int'(bus.fpu_divbusy), 1);
                    @(posedge clk);
                    #1;
                end
                check("divbusy_low", int'(bus.fpu_divbusy), 0);
            end
        join
        idle(25);

        // Writeback slot collision: FMUL then FSGNJX
        t = cyc;
        issue(4'd2, 5'd7, 5'd1, 5'd2, t, 1'b1, 1'b0, 2, 1'b1);
        issue(4'd5, 5'd8, 5'd1, 5'd2, t + 2, 1'b1, 1'b0, 1, 1'b1);
        idle(10);

        // Integer x0 is never pending
        t = cyc;
        issue(4'd6, 5'd0, 5'd1, 5'd2, t, 1'b1, 1'b0, 1, 1'b0);
        issue(4'd9, 5'd9, 5'd0, 5'd0, t + 1, 1'b1, 1'b0, 1, 1'b1);
        idle(10);

        // Integer RAW: FLT x9 then FMVSX rs1=x9
        t = cyc;
        issue(4'd7, 5'd9, 5'd1, 5'd2, t, 1'b1, 1'b0, 1, 1'b0);
        issue(4'd9, 5'd10, 5'd9, 5'd0, t + 3, 1'b1, 1'b0, 1, 1'b1);
        idle(10);

        // Back-to-back independent ops with distinct WB cycles
        t = cyc;
        issue(4'd2, 5'd12, 5'd1, 5'd2, t, 1'b1, 1'b0, 2, 1'b1);
        issue(4'd0, 5'd13, 5'd1, 5'd2, t + 1, 1'b1, 1'b0, 3, 1'b1);
        idle(10);

        // Reset mid-FDIV drops the result and clears the scoreboard
        t = cyc;
        issue(4'd3, 5'd15, 5'd1, 5'd2, t, 1'b0, 1'b0, 10, 1'b1);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("post_rst_divbusy", int'(bus.fpu_divbusy), 0);
        check("post_rst_wb_valid", int'(bus.wb_valid), 0);
        issue(4'd0, 5'd16, 5'd15, 5'd15, t + 4, 1'b1, 1'b0, 3, 1'b1);
        check("post_rst_divbusy2", int'(bus.fpu_divbusy), 0);
        idle(15);

        // FSQRT depends on configuration
        t = cyc;
`ifdef FPU_SQRT_EN
        issue(4'd4, 5'd17, 5'd18, 5'd0, t, 1'b1, 1'b0, 10, 1'b1);
`else
        issue(4'd4, 5'd17, 5'd18, 5'd0, t, 1'b0, 1'b1, 0, 1'b1);
`endif
        idle(15);

        // Illegal op is accepted despite hazards
        t = cyc;
        issue(4'd0, 5'd20, 5'd1, 5'd2, t, 1'b1, 1'b0, 3, 1'b1);
        issue(4'd15, 5'd20, 5'd20, 5'd20, t + 1, 1'b0, 1'b1, 0, 1'b1);
        idle(15);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
